recorre_ram_multicanal: RTL and testbench

Parametrised multi-channel RAM address sequencer for the sample-playback path. It holds one read pointer per channel, each with its own base and limit window. On each `tick` it issues one read address to the RAM controller over a valid/ack handshake, serving channels in round-robin order. Each pointer advances by a level-dependent step and wraps inside its window. It replaces the two-pointer, edge-clocked address walker with a single-clock, N-channel design.

---
 rtl/recorre_ram_pkg.sv | 13 +
 rtl/recorre_ram_multicanal_if.sv | 16 +
 rtl/recorre_ram_canal.sv | 36 +++
 rtl/recorre_ram_multicanal.sv | 159 +++++++++++++++
 tb/tb_recorre_ram_multicanal.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/recorre_ram_pkg.sv
// Shared types and constants for the multi-channel RAM address sequencer.
package recorre_ram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam int DEF_ADDR_W    = 26;
    localparam int DEF_STEP_BASE = 2;
    localparam int OVR_W         = 8;

endpackage

// File: rtl/recorre_ram_multicanal_if.sv
// Read-request bus between the address sequencer (master) and the RAM controller (slave).
interface recorre_ram_multicanal_if #(
    parameter int ADDR_W = 26,
    parameter int CH_W   = 1
);
    // A request transfers on a rising edge where rd_valid && rd_ack. Once
    // rd_valid rises, rd_addr/rd_ch hold until that edge. rd_ack with
    // rd_valid low has no effect.
    logic [ADDR_W-1:0] rd_addr;
    logic [CH_W-1:0]   rd_ch;
    logic              rd_valid;
    logic              rd_ack;

    modport master (output rd_addr, output rd_ch, output rd_valid, input rd_ack);
    modport slave  (input rd_addr, input rd_ch, input rd_valid, output rd_ack);
endinterface

// File: rtl/recorre_ram_canal.sv
// One channel read pointer that walks base..limit by a variable step and wraps to base.
module recorre_ram_canal #(
    parameter int ADDR_W = 26
) (
    input  logic              clk,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    output logic [ADDR_W-1:0] ptr,
    output logic              wrap_now
);
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   nxt;

    // The extra bit catches overflow past the top of the address space.
    assign nxt      = {1'b0, ptr_q} + {1'b0, step};
    assign wrap_now = nxt[ADDR_W] || (nxt > {1'b0, limit});

    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = base;
        end else if (advance) begin
            ptr_d = wrap_now ? base : nxt[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/recorre_ram_multicanal.sv
// Round-robin N-channel RAM read-address sequencer with valid/ack request port.
// Optional macro RECORRE_RAM_OVERRUN_EN adds the saturating dropped-tick counter overrun_cnt.
module recorre_ram_multicanal
    import recorre_ram_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int N_CH      = 2,
    parameter int STEP_BASE = DEF_STEP_BASE,
    parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   restart,
    input  logic [1:0]             nivel,
    input  logic [N_CH*ADDR_W-1:0] base_addr,
    input  logic [N_CH*ADDR_W-1:0] limit_addr,
    recorre_ram_multicanal_if.master rd,
    output logic [N_CH-1:0]        wrap,
    output logic                   busy,
    output state_t                 dbg_state
`ifdef RECORRE_RAM_OVERRUN_EN
    ,
    output logic [OVR_W-1:0]       overrun_cnt
`endif
);
    state_t            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              pend_q, pend_d;
    logic              rst_pend_q, rst_pend_d;
    logic [N_CH-1:0]   wrap_q, wrap_d;
    logic [ADDR_W-1:0] ptr [N_CH];
    logic [N_CH-1:0]   wrap_now;
    logic [N_CH-1:0]   advance;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] sel_ptr;
    logic              accept;
    logic              reload;
    logic              load_all;
    logic              drop;

    assign step     = ADDR_W'(STEP_BASE) + ADDR_W'(nivel);
    assign accept   = (state_q == ST_REQ) && rd.rd_ack;
    assign load_all = reset || reload;

    for (genvar g = 0; g < N_CH; g++) begin : g_canal
        recorre_ram_canal #(.ADDR_W(ADDR_W)) u_canal (
            .clk      (clk),
            .load     (load_all),
            .advance  (advance[g]),
            .step     (step),
            .base     (base_addr[g*ADDR_W +: ADDR_W]),
            .limit    (limit_addr[g*ADDR_W +: ADDR_W]),
            .ptr      (ptr[g]),
            .wrap_now (wrap_now[g])
        );
    end

    always_comb begin
        sel_ptr = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_q == CH_W'(i)) sel_ptr = ptr[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        pend_d     = pend_q;
        rst_pend_d = rst_pend_q;
        wrap_d     = '0;
        advance    = '0;
        reload     = 1'b0;
        drop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Restart beats a same-cycle tick; that tick is simply lost.
                if (restart) begin
                    reload = 1'b1;
                    ch_d   = '0;
                    pend_d = 1'b0;
                end else if (tick || pend_q) begin
                    state_d = ST_REQ;
                    pend_d  = 1'b0;
                end
            end
            ST_REQ: begin
                if (accept) begin
                    if (restart || rst_pend_q) begin
                        reload     = 1'b1;
                        ch_d       = '0;
                        pend_d     = 1'b0;
                        rst_pend_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (ch_q == CH_W'(i)) begin
                                advance[i] = 1'b1;
                                wrap_d[i]  = wrap_now[i];
                            end
                        end
                        ch_d    = (ch_q == CH_W'(N_CH-1)) ? '0 : ch_q + 1'b1;
                        pend_d  = 1'b0;
                        drop    = pend_q && tick;
                        state_d = (pend_q || tick) ? ST_REQ : ST_IDLE;
                    end
                end else begin
                    if (restart) rst_pend_d = 1'b1;
                    if (tick) begin
                        if (pend_q) drop = 1'b1;
                        else        pend_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            pend_q     <= 1'b0;
            rst_pend_q <= 1'b0;
            wrap_q     <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            pend_q     <= pend_d;
            rst_pend_q <= rst_pend_d;
            wrap_q     <= wrap_d;
        end
    end

    assign rd.rd_valid = (state_q == ST_REQ);
    assign rd.rd_addr  = rd.rd_valid ? sel_ptr : '0;
    assign rd.rd_ch    = rd.rd_valid ? ch_q : '0;
    assign wrap        = wrap_q;
    assign busy        = (state_q != ST_IDLE);
    assign dbg_state   = state_q;

`ifdef RECORRE_RAM_OVERRUN_EN
    logic [OVR_W-1:0] ovr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovr_q <= '0;
        end else if (drop && (ovr_q != {OVR_W{1'b1}})) begin
            ovr_q <= ovr_q + 1'b1;
        end
    end

    assign overrun_cnt = ovr_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_recorre_ram_multicanal.sv
// Scoreboard bench for recorre_ram_multicanal (N_CH=2); overrun checks run when RECORRE_RAM_OVERRUN_EN is defined.
module tb_recorre_ram_multicanal;
    import recorre_ram_pkg::*;

    localparam int AW = 26;
    localparam int NC = 2;
    localparam int CW = 1;
    localparam int EW = AW + CW + NC;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic             restart = 1'b0;
    logic [1:0]       nivel = 2'd0;
    logic [NC*AW-1:0] base_addr;
    logic [NC*AW-1:0] limit_addr;
    logic [NC-1:0]    wrap;
    logic             busy;
    state_t           dbg_state;
`ifdef RECORRE_RAM_OVERRUN_EN
    logic [7:0]       overrun_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    recorre_ram_multicanal_if #(.ADDR_W(AW), .CH_W(CW)) rif ();

    recorre_ram_multicanal #(.ADDR_W(AW), .N_CH(NC), .STEP_BASE(2), .CH_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .restart     (restart),
        .nivel       (nivel),
        .base_addr   (base_addr),
        .limit_addr  (limit_addr),
        .rd          (rif),
        .wrap        (wrap),
        .busy        (busy),
        .dbg_state   (dbg_state)
`ifdef RECORRE_RAM_OVERRUN_EN
        ,
        .overrun_cnt (overrun_cnt)
`endif
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Driver tasks
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] addr, input logic [CW-1:0] ch, input logic [NC-1:0] w);
        exp_q.push_back({w, ch, addr});
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic ack_wait();
        int n = 0;
        while (!rif.rd_valid && n < 20) begin
            cyc(1);
            n++;
        end
        if (!rif.rd_valid) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: rd_valid 0 after %0d cycles, required 1", n);
        end else begin
            rif.rd_ack = 1'b1;
            cyc(1);
            rif.rd_ack = 1'b0;
        end
    endtask

    task automatic set_win(input logic [AW-1:0] b0, input logic [AW-1:0] l0,
                           input logic [AW-1:0] b1, input logic [AW-1:0] l1);
        base_addr  = {b1, b0};
        limit_addr = {l1, l0};
    endtask

    task automatic restart_idle();
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
    endtask

    // Scoreboard monitor
    logic          wchk = 1'b0;
    logic [NC-1:0] wexp = '0;
    logic          pv = 1'b0;
    logic          pacc = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [CW-1:0] pch = '0;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (wchk) begin
            check("wrap_pulse", 32'(wrap), 32'(wexp));
            wchk = 1'b0;
        end
        if (rif.rd_valid && pv && !pacc && !reset) begin
            check("hold_addr", 32'(rif.rd_addr), 32'(paddr));
            check("hold_ch", 32'(rif.rd_ch), 32'(pch));
        end
        if (rif.rd_valid && rif.rd_ack && !reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got addr 0x%0h ch %0d, required no request",
                         rif.rd_addr, rif.rd_ch);
            end else begin
                e = exp_q.pop_front();
                check("rd_addr", 32'(rif.rd_addr), 32'(e[AW-1:0]));
                check("rd_ch", 32'(rif.rd_ch), 32'(e[AW+CW-1:AW]));
                wexp = e[EW-1:AW+CW];
                wchk = 1'b1;
            end
        end
        pv    = rif.rd_valid;
        pacc  = rif.rd_valid && rif.rd_ack;
        paddr = rif.rd_addr;
        pch   = rif.rd_ch;
    end

    // Directed stimulus
    initial begin
        rif.rd_ack = 1'b0;
        set_win(26'h0, 26'h0285FF0, 26'h0800000, 26'h08FFFFF);
        reset = 1'b1;
        cyc(3);
        check("rst_valid", 32'(rif.rd_valid), 32'd0);
        check("rst_addr", 32'(rif.rd_addr), 32'd0);
        check("rst_ch", 32'(rif.rd_ch), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        cyc(1);

        // Basic walk, step 2
        push(26'h0, 1'b0, 2'b00);
        push(26'h0800000, 1'b1, 2'b00);
        push(26'h2, 1'b0, 2'b00);
        push(26'h0800002, 1'b1, 2'b00);
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            ack_wait();
        end
        cyc(1);
        check("walk_idle", 32'(busy), 32'd0);

        // Wrap: ch0 window 0x10..0x14 with step 5, ch1 window inverted
        set_win(26'h10, 26'h14, 26'h0800000, 26'h07FFFFF);
        nivel = 2'd3;
        restart_idle();
        for (int i = 0; i < 2; i++) begin
            push(26'h10, 1'b0, 2'b01);
            push(26'h0800000, 1'b1, 2'b10);
        end
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            ack_wait();
        end

        // Back-to-back with stalled ack
        set_win(26'h0, 26'h0285FF0, 26'h0800000, 26'h08FFFFF);
        nivel = 2'd0;
        restart_idle();
        push(26'h0, 1'b0, 2'b00);
        push(26'h0800000, 1'b1, 2'b00);
        pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
        cyc(2);
        rif.rd_ack = 1'b1;
        cyc(1);
        rif.rd_ack = 1'b0;
        check("b2b_valid", 32'(rif.rd_valid), 32'd1);
        check("b2b_addr", 32'(rif.rd_addr), 32'h0800000);
        ack_wait();

        // Restart during a stalled request
        push(26'h2, 1'b0, 2'b00);
        pulse_tick();
        cyc(1);
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
        cyc(1);
        check("rst_mid_valid_held", 32'(rif.rd_valid), 32'd1);
        rif.rd_ack = 1'b1;
        cyc(1);
        rif.rd_ack = 1'b0;
        check("rst_mid_idle", 32'(busy), 32'd0);
        push(26'h0, 1'b0, 2'b00);
        push(26'h0800000, 1'b1, 2'b00);
        for (int i = 0; i < 2; i++) begin
            pulse_tick();
            ack_wait();
        end

        // Reset mid-handshake, then tick coincident with accept
        pulse_tick();
        check("pre_reset_valid", 32'(rif.rd_valid), 32'd1);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        check("reset_mid_valid", 32'(rif.rd_valid), 32'd0);
        check("reset_mid_busy", 32'(busy), 32'd0);
        push(26'h0, 1'b0, 2'b00);
        push(26'h0800000, 1'b1, 2'b00);
        pulse_tick();
        tick = 1'b1;
        rif.rd_ack = 1'b1;
        cyc(1);
        tick = 1'b0;
        rif.rd_ack = 1'b0;
        check("tick_at_accept_valid", 32'(rif.rd_valid), 32'd1);
        ack_wait();

        // Restart and tick in the same idle cycle: tick is lost
        restart = 1'b1;
        tick = 1'b1;
        cyc(1);
        restart = 1'b0;
        tick = 1'b0;
        cyc(2);
        check("restart_tick_idle", 32'(busy), 32'd0);

`ifdef RECORRE_RAM_OVERRUN_EN
        push(26'h0, 1'b0, 2'b00);
        push(26'h0800000, 1'b1, 2'b00);
        tick = 1'b1;
        cyc(1);
        cyc(3);
        check("overrun_two", 32'(overrun_cnt), 32'd2);
        cyc(300);
        check("overrun_sat", 32'(overrun_cnt), 32'd255);
        tick = 1'b0;
        ack_wait();
        ack_wait();
        check("overrun_hold", 32'(overrun_cnt), 32'd255);
`else
        push(26'h0, 1'b0, 2'b00);
        push(26'h0800000, 1'b1, 2'b00);
        for (int i = 0; i < 2; i++) begin
            pulse_tick();
            ack_wait();
        end
`endif

        cyc(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
